// File: rtl/system_pkg.sv
// Shared definitions for the AHB-Lite master front end: bus widths,
// arbiter FSM states, HTRANS encodings and the byte-enable to HSIZE mapping.
package system_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DPH_I = 2'd1,
        DPH_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Byte lanes map onto the narrowest AHB size that covers them; any
    // pattern that is not a single byte or an aligned halfword goes out as a word.
    function automatic logic [2:0] be_to_hsize(input logic [3:0] be);
        logic [2:0] size;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'b000;
            4'b0011, 4'b1100:                   size = 3'b001;
            default:                            size = 3'b010;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/ahbl_arb_pick.sv
// Winner selection between the instruction and data ports. Data wins a
// collision unless prefer_instr is raised (used by the round-robin build).
module ahbl_arb_pick (
    input  logic instr_req,
    input  logic data_req,
    input  logic prefer_instr,
    output logic pick_instr,
    output logic pick_data
);

    // Exactly one winner whenever at least one port requests.
    always_comb begin
        pick_data  = data_req && !(instr_req && prefer_instr);
        pick_instr = instr_req && !pick_data;
    end

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Single-master AHB-Lite front end shared by the Ibex instruction and data
// ports. Single transfers only; address phase is combinational from the
// requests, data phase tracked by a three-state FSM.
// Optional build macro AHBL_ARB_ROUND_ROBIN_EN: alternate the winner on
// simultaneous requests instead of fixed data priority.
module ahbl_master_arbiter
    import system_pkg::*;
#(
    parameter logic [3:0] INSTR_HPROT = 4'b0010,
    parameter logic [3:0] DATA_HPROT  = 4'b0011
) (
    input  logic                  clk_cpu,
    input  logic                  rstn_cpu,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [3:0]            hprot_o,
    output logic [2:0]            hsize_o,
    output logic [1:0]            htrans_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    output logic                  hwrite_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic                  hresp_i
);

    arb_state_e            state;
    arb_state_e            state_next;
    logic                  wr_q;
    logic                  wr_next;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  err_first;
    logic                  addr_phase;
    logic                  pick_instr;
    logic                  pick_data;
    logic                  prefer_instr;

    // First cycle of a two-cycle error response: the slave is still stalling
    // but has flagged an error, so no new transfer may be started.
    assign err_first  = (state != IDLE) && hresp_i && !hready_i;
    // Reset gating keeps the grant and address outputs quiet while rstn_cpu is low.
    assign addr_phase = rstn_cpu && hready_i && (instr_req_i || data_req_i) && !err_first;

`ifdef AHBL_ARB_ROUND_ROBIN_EN
    logic last_data;

    // Remember which port won the most recent grant; INSTR after reset so data goes first.
    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            last_data <= 1'b0;
        end else if (addr_phase) begin
            last_data <= pick_data;
        end
    end

    assign prefer_instr = last_data;
`else
    assign prefer_instr = 1'b0;
`endif

    ahbl_arb_pick u_pick (
        .instr_req    (instr_req_i),
        .data_req     (data_req_i),
        .prefer_instr (prefer_instr),
        .pick_instr   (pick_instr),
        .pick_data    (pick_data)
    );

    // Data-phase state plus the write flag and write data captured at grant.
    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state   <= state_next;
            wr_q    <= wr_next;
            wdata_q <= wdata_next;
        end
    end

    // Address phase for the winner, data-phase response routing and next state.
    always_comb begin
        state_next     = state;
        wr_next        = wr_q;
        wdata_next     = wdata_q;
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        rdata_o        = '0;
        err_o          = 1'b0;
        haddr_o        = '0;
        hprot_o        = 4'b0000;
        hsize_o        = 3'b000;
        htrans_o       = HTRANS_IDLE;
        hwdata_o       = '0;
        hwrite_o       = 1'b0;

        if (addr_phase) begin
            htrans_o = HTRANS_NONSEQ;
            if (pick_data) begin
                data_gnt_o = 1'b1;
                haddr_o    = data_addr_i;
                hwrite_o   = data_we_i;
                hprot_o    = DATA_HPROT;
                hsize_o    = be_to_hsize(data_be_i);
                state_next = DPH_D;
                wr_next    = data_we_i;
                wdata_next = data_wdata_i;
            end else if (pick_instr) begin
                instr_gnt_o = 1'b1;
                haddr_o     = instr_addr_i;
                hprot_o     = INSTR_HPROT;
                hsize_o     = 3'b010;
                state_next  = DPH_I;
                wr_next     = 1'b0;
            end
        end else if (hready_i) begin
            state_next = IDLE;
        end

        case (state)
            DPH_I: begin
                if (hready_i) begin
                    instr_rvalid_o = 1'b1;
                    rdata_o        = hrdata_i;
                    err_o          = hresp_i;
                end
            end
            DPH_D: begin
                if (wr_q) begin
                    hwdata_o = wdata_q;
                end
                if (hready_i) begin
                    data_rvalid_o = 1'b1;
                    rdata_o       = hrdata_i;
                    err_o         = hresp_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_ahbl_master_arbiter;

    import system_pkg::*;

`ifdef AHBL_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                  clk_cpu = 1'b0;
    logic                  rstn_cpu;
    logic                  instr_req_i;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic                  data_req_i;
    logic                  data_we_i;
    logic [3:0]            data_be_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;
    logic [ADDR_WIDTH-1:0] haddr_o;
    logic [3:0]            hprot_o;
    logic [2:0]            hsize_o;
    logic [1:0]            htrans_o;
    logic [DATA_WIDTH-1:0] hwdata_o;
    logic                  hwrite_o;
    logic [DATA_WIDTH-1:0] hrdata_i;
    logic                  hready_i;
    logic                  hresp_i;

    int tests = 0;
    int fails = 0;

    always #5 clk_cpu = ~clk_cpu;

    ahbl_master_arbiter dut (
        .clk_cpu        (clk_cpu),
        .rstn_cpu       (rstn_cpu),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .haddr_o        (haddr_o),
        .hprot_o        (hprot_o),
        .hsize_o        (hsize_o),
        .htrans_o       (htrans_o),
        .hwdata_o       (hwdata_o),
        .hwrite_o       (hwrite_o),
        .hrdata_i       (hrdata_i),
        .hready_i       (hready_i),
        .hresp_i        (hresp_i)
    );

    task automatic next_cycle();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_cpu);
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = '0;
        data_wdata_i = '0;
        hrdata_i     = '0;
        hready_i     = 1'b1;
        hresp_i      = 1'b0;
    endtask

    task automatic test_reset();
        rstn_cpu    = 1'b0;
        idle_inputs();
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        hrdata_i    = 32'h1234_5678;
        next_cycle();
        sample();
        tests++; if (htrans_o !== 2'b00) begin fails++; $display("FAIL reset_htrans got=%h exp=%h", htrans_o, 2'b00); end
        tests++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin fails++; $display("FAIL reset_gnt got=%b exp=%b", {instr_gnt_o, data_gnt_o}, 2'b00); end
        tests++; if ({instr_rvalid_o, data_rvalid_o, err_o} !== 3'b000) begin fails++; $display("FAIL reset_rvalid got=%b exp=%b", {instr_rvalid_o, data_rvalid_o, err_o}, 3'b000); end
        tests++; if ({haddr_o, hwdata_o, rdata_o} !== 96'h0) begin fails++; $display("FAIL reset_buses got=%h exp=0", {haddr_o, hwdata_o, rdata_o}); end
        next_cycle();
        idle_inputs();
        rstn_cpu = 1'b1;
        next_cycle();
    endtask

    task automatic test_instr_fetch();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0100;
        hrdata_i     = 32'h0000_0013;
        sample();
        tests++; if (instr_gnt_o !== 1'b1) begin fails++; $display("FAIL fetch_gnt got=%b exp=1", instr_gnt_o); end
        tests++; if (htrans_o !== 2'b10) begin fails++; $display("FAIL fetch_htrans got=%h exp=2", htrans_o); end
        tests++; if ({haddr_o, hsize_o, hprot_o, hwrite_o} !== {32'h100, 3'b010, 4'b0010, 1'b0}) begin fails++; $display("FAIL fetch_addr_ctrl got=%h/%b/%b/%b exp=100/010/0010/0", haddr_o, hsize_o, hprot_o, hwrite_o); end
        next_cycle();
        instr_req_i = 1'b0;
        sample();
        tests++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin fails++; $display("FAIL fetch_rvalid got=%b exp=10", {instr_rvalid_o, data_rvalid_o}); end
        tests++; if (rdata_o !== 32'h13) begin fails++; $display("FAIL fetch_rdata got=%h exp=13", rdata_o); end
        tests++; if ({htrans_o, haddr_o} !== 34'h0) begin fails++; $display("FAIL fetch_idle_after got=%h/%h exp=0/0", htrans_o, haddr_o); end
        next_cycle();
        sample();
        tests++; if ({instr_rvalid_o, rdata_o} !== 33'h0) begin fails++; $display("FAIL fetch_quiet got=%b/%h exp=0/0", instr_rvalid_o, rdata_o); end
        next_cycle();
    endtask

    task automatic test_collision();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0100;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_0200;
        data_be_i    = 4'hF;
        sample();
        tests++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin fails++; $display("FAIL coll1_gnt got=%b exp=01", {instr_gnt_o, data_gnt_o}); end
        tests++; if ({haddr_o, hprot_o} !== {32'h200, 4'b0011}) begin fails++; $display("FAIL coll1_addr got=%h/%b exp=200/0011", haddr_o, hprot_o); end
        next_cycle();
        data_req_i = 1'b0;
        hrdata_i   = 32'hAAAA_0001;
        sample();
        tests++; if ({instr_gnt_o, data_gnt_o, haddr_o} !== {2'b10, 32'h100}) begin fails++; $display("FAIL coll2_gnt got=%b/%h exp=10/100", {instr_gnt_o, data_gnt_o}, haddr_o); end
        tests++; if ({data_rvalid_o, instr_rvalid_o, rdata_o} !== {2'b10, 32'hAAAA_0001}) begin fails++; $display("FAIL coll2_rsp got=%b/%h exp=10/aaaa0001", {data_rvalid_o, instr_rvalid_o}, rdata_o); end
        next_cycle();
        instr_req_i = 1'b0;
        hrdata_i    = 32'hBBBB_0002;
        sample();
        tests++; if ({instr_rvalid_o, data_rvalid_o, rdata_o} !== {2'b10, 32'hBBBB_0002}) begin fails++; $display("FAIL coll3_rsp got=%b/%h exp=10/bbbb0002", {instr_rvalid_o, data_rvalid_o}, rdata_o); end
        next_cycle();
    endtask

    task automatic test_second_collision();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr;
        logic [1:0]  exp_rv;
        exp_gnt  = RR ? 2'b10 : 2'b01;
        exp_addr = RR ? 32'h104 : 32'h204;
        exp_rv   = RR ? 2'b10 : 2'b01;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0104;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_0204;
        sample();
        tests++; if ({instr_gnt_o, data_gnt_o, haddr_o} !== {2'b01, 32'h204}) begin fails++; $display("FAIL coll_b1_gnt got=%b/%h exp=01/204", {instr_gnt_o, data_gnt_o}, haddr_o); end
        next_cycle();
        sample();
        tests++; if ({instr_gnt_o, data_gnt_o, haddr_o} !== {exp_gnt, exp_addr}) begin fails++; $display("FAIL coll_b2_gnt got=%b/%h exp=%b/%h", {instr_gnt_o, data_gnt_o}, haddr_o, exp_gnt, exp_addr); end
        next_cycle();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        sample();
        tests++; if ({instr_rvalid_o, data_rvalid_o} !== exp_rv) begin fails++; $display("FAIL coll_b3_rsp got=%b exp=%b", {instr_rvalid_o, data_rvalid_o}, exp_rv); end
        next_cycle();
    endtask

    task automatic test_hsize();
        logic [3:0] be_tab [9];
        logic [2:0] sz_tab [9];
        be_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b0110, 4'b1111, 4'b0000};
        sz_tab = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010};
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h0000_0240;
        for (int i = 0; i < 9; i++) begin
            data_be_i = be_tab[i];
            sample();
            tests++; if ({data_gnt_o, hsize_o} !== {1'b1, sz_tab[i]}) begin fails++; $display("FAIL hsize_be%b got=%b/%b exp=1/%b", be_tab[i], data_gnt_o, hsize_o, sz_tab[i]); end
            next_cycle();
        end
        data_req_i = 1'b0;
        hrdata_i   = 32'h5555_AAAA;
        sample();
        tests++; if ({data_rvalid_o, rdata_o} !== {1'b1, 32'h5555_AAAA}) begin fails++; $display("FAIL hsize_last_rsp got=%b/%h exp=1/5555aaaa", data_rvalid_o, rdata_o); end
        next_cycle();
        data_be_i = 4'hF;
    endtask

    task automatic test_wait_write();
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'b1100;
        data_addr_i  = 32'h0000_0300;
        data_wdata_i = 32'hDEAD_BEEF;
        sample();
        tests++; if ({data_gnt_o, htrans_o, hsize_o, hwrite_o} !== {1'b1, 2'b10, 3'b001, 1'b1}) begin fails++; $display("FAIL wr_addr got=%b/%h/%b/%b exp=1/2/001/1", data_gnt_o, htrans_o, hsize_o, hwrite_o); end
        next_cycle();
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_wdata_i = 32'h0;
        hready_i     = 1'b0;
        for (int w = 0; w < 2; w++) begin
            sample();
            tests++; if ({hwdata_o, data_rvalid_o, htrans_o} !== {32'hDEAD_BEEF, 1'b0, 2'b00}) begin fails++; $display("FAIL wr_wait%0d got=%h/%b/%h exp=deadbeef/0/0", w, hwdata_o, data_rvalid_o, htrans_o); end
            next_cycle();
        end
        hready_i = 1'b1;
        sample();
        tests++; if ({hwdata_o, data_rvalid_o, err_o} !== {32'hDEAD_BEEF, 1'b1, 1'b0}) begin fails++; $display("FAIL wr_done got=%h/%b/%b exp=deadbeef/1/0", hwdata_o, data_rvalid_o, err_o); end
        next_cycle();
        sample();
        tests++; if ({hwdata_o, data_rvalid_o} !== 33'h0) begin fails++; $display("FAIL wr_after got=%h/%b exp=0/0", hwdata_o, data_rvalid_o); end
        next_cycle();
        data_be_i = 4'hF;
    endtask

    task automatic test_error();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0600;
        sample();
        tests++; if (data_gnt_o !== 1'b1) begin fails++; $display("FAIL err_grant got=%b exp=1", data_gnt_o); end
        next_cycle();
        data_req_i  = 1'b0;
        instr_req_i = 1'b1;
        hready_i    = 1'b0;
        hresp_i     = 1'b1;
        sample();
        tests++; if ({htrans_o, instr_gnt_o, data_gnt_o, data_rvalid_o} !== 5'b0) begin fails++; $display("FAIL err_first got=%h/%b/%b/%b exp=0/0/0/0", htrans_o, instr_gnt_o, data_gnt_o, data_rvalid_o); end
        next_cycle();
        instr_req_i = 1'b0;
        hready_i    = 1'b1;
        sample();
        tests++; if ({data_rvalid_o, err_o} !== 2'b11) begin fails++; $display("FAIL err_second got=%b/%b exp=1/1", data_rvalid_o, err_o); end
        next_cycle();
        hresp_i = 1'b0;
        sample();
        tests++; if ({data_rvalid_o, err_o} !== 2'b00) begin fails++; $display("FAIL err_after got=%b/%b exp=0/0", data_rvalid_o, err_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h0000_0400;
        data_wdata_i = 32'hCAFE_F00D;
        sample();
        tests++; if (data_gnt_o !== 1'b1) begin fails++; $display("FAIL rst_mid_grant got=%b exp=1", data_gnt_o); end
        next_cycle();
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
        hready_i   = 1'b0;
        #1;
        tests++; if (hwdata_o !== 32'hCAFE_F00D) begin fails++; $display("FAIL rst_mid_pre got=%h exp=cafef00d", hwdata_o); end
        #1;
        rstn_cpu   = 1'b0;
        data_req_i = 1'b1;
        hready_i   = 1'b1;
        #1;
        tests++; if ({htrans_o, data_gnt_o, instr_gnt_o, data_rvalid_o} !== 5'b0) begin fails++; $display("FAIL rst_mid_ctrl got=%h/%b/%b/%b exp=0/0/0/0", htrans_o, data_gnt_o, instr_gnt_o, data_rvalid_o); end
        tests++; if ({hwdata_o, haddr_o} !== 64'h0) begin fails++; $display("FAIL rst_mid_bus got=%h/%h exp=0/0", hwdata_o, haddr_o); end
        next_cycle();
        data_req_i = 1'b0;
        rstn_cpu   = 1'b1;
        sample();
        tests++; if ({data_rvalid_o, instr_rvalid_o, hwdata_o} !== 34'h0) begin fails++; $display("FAIL rst_mid_norv got=%b/%b/%h exp=0/0/0", data_rvalid_o, instr_rvalid_o, hwdata_o); end
        next_cycle();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0500;
        sample();
        tests++; if ({data_gnt_o, htrans_o, haddr_o} !== {1'b1, 2'b10, 32'h500}) begin fails++; $display("FAIL rst_mid_regrant got=%b/%h/%h exp=1/2/500", data_gnt_o, htrans_o, haddr_o); end
        next_cycle();
        data_req_i = 1'b0;
        hrdata_i   = 32'h0BAD_CAFE;
        sample();
        tests++; if ({data_rvalid_o, rdata_o} !== {1'b1, 32'h0BAD_CAFE}) begin fails++; $display("FAIL rst_mid_rsp got=%b/%h exp=1/0badcafe", data_rvalid_o, rdata_o); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_instr_fetch();
        test_collision();
        test_second_collision();
        test_hsize();
        test_wait_write();
        test_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahbl_master_arbiter.md
AHBL_MASTER_ARBITER -- requirements
Module: ahbl_master_arbiter

Interface
REQ-001 The block SHALL have parameter INSTR_HPROT, default 4'b0010, giving the hprot value for instruction fetches (opcode, privileged).
REQ-002 The block SHALL have parameter DATA_HPROT, default 4'b0011, giving the hprot value for data accesses (data, privileged).
REQ-003 The block SHALL have port clk_cpu  input  1  clock; reset rstn_cpu, asynchronous, active-low; clock clk_cpu.
REQ-004 The block SHALL have port rstn_cpu  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port instr_req_i  input  1  instruction request.
REQ-006 The block SHALL have port instr_addr_i  input  ADDR_WIDTH  fetch address.
REQ-007 The block SHALL have port instr_gnt_o  output  1  instruction address accepted.
REQ-008 The block SHALL have port instr_rvalid_o  output  1  instruction response valid.
REQ-009 The block SHALL have port data_req_i  input  1  data request.
REQ-010 The block SHALL have port data_we_i  input  1  write enable.
REQ-011 The block SHALL have port data_be_i  input  4  byte enables.
REQ-012 The block SHALL have port data_addr_i  input  ADDR_WIDTH  data address.
REQ-013 The block SHALL have port data_wdata_i  input  DATA_WIDTH  write data.
REQ-014 The block SHALL have port data_gnt_o  output  1  data address accepted.
REQ-015 The block SHALL have port data_rvalid_o  output  1  data response valid.
REQ-016 The block SHALL have port rdata_o  output  DATA_WIDTH  shared read data, qualified by instr_rvalid_o or data_rvalid_o.
REQ-017 The block SHALL have port err_o  output  1  shared error flag, qualified by instr_rvalid_o or data_rvalid_o.
REQ-018 The block SHALL have port haddr_o  output  ADDR_WIDTH  AHB address.
REQ-019 The block SHALL have port hprot_o  output  4  AHB protection.
REQ-020 The block SHALL have port hsize_o  output  3  AHB transfer size.
REQ-021 The block SHALL have port htrans_o  output  2  AHB transfer type, IDLE (2'b00) or NONSEQ (2'b10) only.
REQ-022 The block SHALL have port hwdata_o  output  DATA_WIDTH  AHB write data.
REQ-023 The block SHALL have port hwrite_o  output  1  AHB write.
REQ-024 The block SHALL have port hrdata_i  input  DATA_WIDTH  AHB read data.
REQ-025 The block SHALL have port hready_i  input  1  AHB ready.
REQ-026 The block SHALL have port hresp_i  input  1  AHB error response.

Function
REQ-027 The block SHALL be a single-master AHB-Lite front end shared by the Ibex instruction and data ports, with single transfers only; hburst is tied to SINGLE and hmastlock to 0 outside the block.
REQ-028 The FSM SHALL have states IDLE (no data phase pending), DPH_I (instruction data phase) and DPH_D (data data phase).
REQ-029 An address phase SHALL occur in any cycle with hready_i=1, at least one request, and no pending error first cycle; in that cycle htrans_o=NONSEQ, the selected port's gnt is asserted combinationally, and haddr/hwrite/hprot/hsize reflect the winner.
REQ-030 Otherwise htrans_o SHALL be IDLE, haddr_o, hsize_o and hprot_o SHALL be 0, and both gnt outputs SHALL be 0.
REQ-031 hsize_o for data SHALL be: one-hot data_be_i -> 3'b000; 4'b0011 or 4'b1100 -> 3'b001; else 3'b010; instruction fetches SHALL always use 3'b010 with hwrite_o=0.
REQ-032 On grant, the FSM SHALL move to DPH_I or DPH_D and register the write flag and data_wdata_i; on a cycle with hready_i=1 and no new grant, it SHALL move to IDLE.
REQ-033 hwdata_o SHALL carry the registered write data during a DPH_D write, and 0 otherwise.
REQ-034 In DPH_x with hready_i=1, the owner's rvalid SHALL pulse for 1 cycle with rdata_o=hrdata_i and err_o=hresp_i; in all other cycles rdata_o and err_o SHALL be 0.
REQ-035 Latency SHALL be: gnt in cycle N, rvalid in cycle N+1 at zero wait states, with each wait state (hready_i=0) adding 1 cycle.
REQ-036 A response and a new grant in the same cycle SHALL both be honoured (back-to-back pipelining).
REQ-037 In a DPH_x cycle with hresp_i=1 and hready_i=0 (first error cycle), the block SHALL force htrans_o=IDLE and suppress all grants.
REQ-038 When both ports request, the default arbitration SHALL grant data (fixed priority).

Reset
REQ-039 While rstn_cpu=0, the block SHALL hold state IDLE, clear the write-data register, and drive all outputs to 0 (htrans_o=IDLE); any in-flight transfer SHALL be dropped without rvalid, and the round-robin last-winner flag SHALL be reset to INSTR.

Configuration
REQ-040 With macro AHBL_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not granted last (data first after reset), with the last-winner flag updated on each grant; without the macro, the block SHALL use fixed data priority and SHALL contain no last-winner flag.

Structure
REQ-041 The shared package system_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, the enum arb_state_e {IDLE, DPH_I, DPH_D}, the HTRANS_IDLE/HTRANS_NONSEQ constants, and the be-to-hsize function.
REQ-042 Winner selection SHALL be implemented in the single combinational sub-module ahbl_arb_pick.

Verification
REQ-043 Bench SHALL check: instr_req=1, addr 0x100, hready=1, hrdata=0x00000013 -> instr_gnt and NONSEQ in cycle 0; instr_rvalid=1, rdata=0x13 in cycle 1.
REQ-044 Bench SHALL check: simultaneous instr and data read requests -> data granted first; instr granted next cycle with rvalid responses back-to-back (with the macro defined after reset, same order; a second collision grants instr).
REQ-045 Bench SHALL check: data write be=4'b1100, wdata 0xDEADBEEF, hready low 2 cycles -> hsize=001, hwdata=0xDEADBEEF held until hready, data_rvalid 3 cycles after gnt.
REQ-046 Bench SHALL check: hresp=1 with hready=0 then hresp=1 with hready=1 -> htrans IDLE and no gnt in the first cycle; rvalid=1 and err_o=1 in the second.
REQ-047 Bench SHALL check: rstn_cpu asserted during a waited data phase -> outputs 0 immediately; no rvalid after release; next request is granted from IDLE.
